// File: rtl/raster_sink.sv
// Consumer end of the raster pixel stream. It buffers (x, y, color) pixels in a small FIFO,
// writes them out as linear framebuffer addresses and checks that they arrive in raster order.
module raster_sink #(
    parameter int WIDTH       = 8,
    parameter int COLOR_WIDTH = 3,
    parameter int ADDR_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x_max,
    input  logic [WIDTH-1:0]       y_max,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_x,
    input  logic [WIDTH-1:0]       in_y,
    input  logic [COLOR_WIDTH-1:0] in_color,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [COLOR_WIDTH-1:0] mem_data,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   seq_error
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PROD_W = 2 * WIDTH + 2;
    localparam int FULL_W = (PROD_W > ADDR_WIDTH) ? PROD_W : ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Row-major address, formed at full precision before truncation to the port width.
    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] xm
    );
        logic [FULL_W-1:0] stride;
        logic [FULL_W-1:0] full;
        stride = FULL_W'(xm) + FULL_W'(1);
        full   = FULL_W'(y) * stride + FULL_W'(x);
        return full[ADDR_WIDTH-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       x_max_q, x_max_d;
    logic [WIDTH-1:0]       y_max_q, y_max_d;
    logic [WIDTH-1:0]       ex_q, ex_d;
    logic [WIDTH-1:0]       ey_q, ey_d;
    logic                   seq_error_q, seq_error_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;

    logic [ADDR_WIDTH-1:0]  fifo_addr_q  [FIFO_DEPTH];
    logic [COLOR_WIDTH-1:0] fifo_color_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_addr_d;
    logic [COLOR_WIDTH-1:0] fifo_color_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic last_pixel;
    logic coord_ok;

    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        in_ready   = (state_q == S_RUN) && !fifo_full;
        push       = in_valid && in_ready;
        mem_we     = !fifo_empty;
        pop        = mem_we && mem_ready;
        // Head is gated so the outputs read zero whenever nothing is queued.
        mem_addr   = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
        mem_data   = fifo_empty ? '0 : fifo_color_q[rd_ptr_q];
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        seq_error  = seq_error_q;
        last_pixel = (ex_q == x_max_q) && (ey_q == y_max_q);
        coord_ok   = (in_x == ex_q) && (in_y == ey_q);
        fifo_addr_d  = pixel_addr(in_x, in_y, x_max_q);
        fifo_color_d = in_color;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        x_max_d     = x_max_q;
        y_max_d     = y_max_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        seq_error_d = seq_error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_max_d     = x_max;
                    y_max_d     = y_max;
                    ex_d        = '0;
                    ey_d        = '0;
                    seq_error_d = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    if (!coord_ok) begin
                        seq_error_d = 1'b1;
                    end
                    // Completion follows the expected pointer, so a bad stream still terminates.
                    if (ex_q == x_max_q) begin
                        ex_d = '0;
                        ey_d = ey_q + WIDTH'(1);
                    end else begin
                        ex_d = ex_q + WIDTH'(1);
                    end
                    if (last_pixel) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_max_q     <= '0;
            y_max_q     <= '0;
            ex_q        <= '0;
            ey_q        <= '0;
            seq_error_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_max_q     <= x_max_d;
            y_max_q     <= y_max_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            seq_error_q <= seq_error_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage is discarded on reset by clearing the pointers; the words themselves need no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= fifo_addr_d;
            fifo_color_q[wr_ptr_q] <= fifo_color_d;
        end
    end

endmodule

// File: tb/tb_raster_sink.sv
// Bench for raster_sink: a frame-level model checked every cycle, plus directed frames
// with literal expected writes.
module tb_raster_sink;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  x_max, y_max, in_x, in_y;
    logic        in_valid, in_ready;
    logic [2:0]  in_color, mem_data;
    logic [15:0] mem_addr;
    logic        mem_we, mem_ready, busy, frame_done, seq_error;

    raster_sink #(.WIDTH(8), .COLOR_WIDTH(3), .ADDR_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .x_max(x_max), .y_max(y_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_color(in_color), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .seq_error(seq_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Frame-level model: pending writes, accept count, frame phase, error flag.
    logic [18:0] mq[$];
    int m_xm, m_ym, m_total, m_nacc;
    bit m_run, m_drain, m_done, m_err;

    always @(posedge clock or posedge reset) begin : model
        bit idle, acc, pop;
        int ex, ey;
        if (reset) begin
            mq.delete();
            m_xm = 0; m_ym = 0; m_total = 0; m_nacc = 0;
            m_run = 0; m_drain = 0; m_done = 0; m_err = 0;
        end else begin
            idle = !m_run && !m_drain && !m_done;
            acc  = m_run && (mq.size() < DEPTH) && in_valid;
            pop  = (mq.size() > 0) && mem_ready;
            if (pop) void'(mq.pop_front());
            m_done = 0;
            if (acc) begin
                ex = m_nacc % (m_xm + 1);
                ey = m_nacc / (m_xm + 1);
                if (int'(in_x) != ex || int'(in_y) != ey) m_err = 1;
                mq.push_back({16'(int'(in_y) * (m_xm + 1) + int'(in_x)), in_color});
                m_nacc++;
                if (m_nacc == m_total) begin
                    m_run = 0;
                    m_drain = 1;
                end
            end else if (m_drain && mq.size() == 0) begin
                m_drain = 0;
                m_done = 1;
            end
            if (idle && start) begin
                m_xm = int'(x_max);
                m_ym = int'(y_max);
                m_total = (m_xm + 1) * (m_ym + 1);
                m_nacc = 0;
                m_run = 1;
                m_err = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("in_ready", in_ready, m_run && (mq.size() < DEPTH));
            check("mem_we", mem_we, mq.size() > 0);
            check("busy", busy, m_run || m_drain || m_done);
            check("frame_done", frame_done, m_done);
            check("seq_error", seq_error, m_err);
            if (mq.size() > 0) begin
                check("mem_addr", mem_addr, mq[0][18:3]);
                check("mem_data", mem_data, mq[0][2:0]);
            end
        end
    end

    logic [18:0] wlog[$];
    int done_cnt;
    int acc_cnt;

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we && mem_ready) wlog.push_back({mem_addr, mem_data});
            if (frame_done) done_cnt++;
            if (in_valid && in_ready) acc_cnt++;
        end
    end

    task automatic start_frame(input int xm, input int ym);
        x_max = 8'(xm);
        y_max = 8'(ym);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int c);
        int t;
        in_x = 8'(x);
        in_y = 8'(y);
        in_color = 3'(c);
        in_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clock);
            if (in_ready) break;
        end
        check("send accepted in time", t < 200, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 2000; t++) begin
            if (!busy) break;
            @(posedge clock); #1;
        end
        check("frame finished in time", busy, 0);
    endtask

    task automatic check_write(input string name, input int idx, input int addr, input int data);
        if (idx < wlog.size()) begin
            check({name, " addr"}, wlog[idx][18:3], addr);
            check({name, " data"}, wlog[idx][2:0], data);
        end else begin
            check({name, " present"}, 0, 1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x_max = '0; y_max = '0;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0; mem_ready = 1'b1;
        done_cnt = 0; acc_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_data", mem_data, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset seq_error", seq_error, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 3x2 frame in raster order, colours 1..6
        wlog.delete(); done_cnt = 0;
        start_frame(2, 1);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 3; x++)
                send(x, y, y * 3 + x + 1);
        wait_idle();
        check("t1 write count", wlog.size(), 6);
        for (int i = 0; i < 6; i++) check_write("t1 write", i, i, i + 1);
        check("t1 done pulses", done_cnt, 1);
        check("t1 seq_error", seq_error, 0);

        // Backpressure: FIFO fills to 4, then drains in order
        wlog.delete(); done_cnt = 0; acc_cnt = 0;
        mem_ready = 1'b0;
        start_frame(7, 0);
        fork
            for (int i = 0; i < 8; i++) send(i, 0, i);
            begin
                repeat (10) @(posedge clock);
                #1;
                check("t2 accepts while stalled", acc_cnt, 4);
                check("t2 in_ready while full", in_ready, 0);
                check("t2 head addr", mem_addr, 0);
                mem_ready = 1'b1;
                repeat (4) @(posedge clock);
                #1;
                check("t2 writes after 4 cycles", wlog.size(), 4);
                for (int i = 0; i < 4; i++) check_write("t2 drain", i, i, i);
            end
        join
        wait_idle();
        check("t2 write count", wlog.size(), 8);
        check_write("t2 last", 7, 7, 7);
        check("t2 done pulses", done_cnt, 1);

        // Out-of-order pixels still written and the frame still completes
        wlog.delete(); done_cnt = 0;
        start_frame(1, 0);
        send(1, 0, 2);
        check("t3 seq_error after first", seq_error, 1);
        send(0, 0, 4);
        wait_idle();
        check_write("t3 first", 0, 1, 2);
        check_write("t3 second", 1, 0, 4);
        check("t3 done pulses", done_cnt, 1);
        check("t3 seq_error sticky", seq_error, 1);

        // Single pixel frame; start in RUN is ignored
        wlog.delete(); done_cnt = 0;
        start_frame(0, 0);
        check("t5 seq_error cleared", seq_error, 0);
        x_max = 8'd7; y_max = 8'd7; start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0;
        check("t5 busy in run", busy, 1);
        send(0, 0, 5);
        wait_idle();
        check("t5 write count", wlog.size(), 1);
        check_write("t5 write", 0, 0, 5);
        check("t5 done pulses", done_cnt, 1);

        // Reset mid-frame with three entries queued
        mem_ready = 1'b0;
        start_frame(7, 0);
        for (int i = 0; i < 3; i++) send(i, 0, i + 1);
        #2;
        reset = 1'b1;
        #1;
        check("t4 in_ready in reset", in_ready, 0);
        check("t4 mem_we in reset", mem_we, 0);
        check("t4 busy in reset", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        wlog.delete(); done_cnt = 0;
        @(posedge clock); #1;
        start_frame(0, 0);
        send(0, 0, 3);
        wait_idle();
        check("t4 write count", wlog.size(), 1);
        check_write("t4 write", 0, 0, 3);
        check("t4 done pulses", done_cnt, 1);

        // Maximum geometry 256x256
        wlog.delete(); done_cnt = 0;
        start_frame(255, 255);
        for (int i = 0; i < 65535; i++) send(i % 256, i / 256, i % 8);
        check("t6 no done before last", done_cnt, 0);
        check("t6 busy before last", busy, 1);
        send(255, 255, 7);
        wait_idle();
        check("t6 write count", wlog.size(), 65536);
        check_write("t6 last", 65535, 65535, 7);
        check("t6 done pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/raster_sink.md
Name: raster_sink

Overview:
Consumer end of the raster coordinate stream. Upstream, a grid-walking source produces pixels as (x, y, color) in raster order.
- raster_sink accepts them over a valid/ready handshake and buffers them in a small FIFO.
- It converts each pixel to a linear framebuffer address and writes it out through a memory write port that can apply backpressure.
- It checks that pixels arrive in strict raster order and signals end of frame.
- It sits between the rasterizer/fill engines and the framebuffer RAM.

Parameters:
WIDTH, 8, bit width of x/y coordinates and of x_max/y_max
COLOR_WIDTH, 3, bit width of pixel colour
ADDR_WIDTH, 16, bit width of framebuffer address
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin a frame; honoured only in IDLE
x_max  in  WIDTH  last column index; latched on accepted start
y_max  in  WIDTH  last row index; latched on accepted start
in_valid  in  1  upstream pixel valid
in_ready  out  1  sink can accept a pixel
in_x  in  WIDTH  pixel column
in_y  in  WIDTH  pixel row
in_color  in  COLOR_WIDTH  pixel colour
mem_addr  out  ADDR_WIDTH  write address (FIFO head)
mem_data  out  COLOR_WIDTH  write data (FIFO head)
mem_we  out  1  write request; high when FIFO non-empty
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  state is not IDLE
frame_done  out  1  single-cycle pulse at frame completion
seq_error  out  1  sticky flag: an out-of-order pixel was received

Behaviour:
- Reset values:
  - state IDLE; FIFO empty.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0.
  - busy=0, frame_done=0, seq_error=0.
  - expected coordinates (ex,ey)=(0,0); latched maxima 0.
- Reset has priority over every other input and may assert mid-frame; FIFO contents are discarded.
- States:
  - IDLE: in_ready=0. start=1 latches x_max/y_max, sets (ex,ey)=(0,0), clears seq_error, goes to RUN.
  - RUN: in_ready = FIFO not full.
    - Accept happens when in_valid & in_ready.
    - On accept, push {addr, color}, where addr = in_y*(x_max_latched+1)+in_x, computed at full width then truncated to ADDR_WIDTH.
    - If (in_x,in_y) != (ex,ey), set seq_error. The pixel is still written.
    - Advance the expected pointer: ex==x_max ? (ex=0, ey++) : ex++.
    - If the accepted pixel is the expected last pixel (ex==x_max & ey==y_max before the advance), go to DRAIN.
  - DRAIN: in_ready=0. When FIFO is empty (including the pop this cycle), go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Memory side:
  - mem_we = FIFO non-empty; mem_addr/mem_data show the head combinationally.
  - Pop when mem_we & mem_ready.
  - mem_addr/mem_data are don't-care when mem_we=0, but must hold stable while mem_we=1 and mem_ready=0.
- Latency: an accepted pixel appears on mem_we/mem_addr no earlier than the next cycle; no pass-through.
- FIFO rules:
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - in_ready is computed from the registered full flag only, so no simultaneous-pop lookahead.
- FIFO order is strict: writes leave in acceptance order.
- seq_error persists through DRAIN/DONE/IDLE until the next accepted start or reset.
- Frame completion is keyed to the expected pointer, not the received coordinates. An erroneous stream still finishes after (x_max+1)*(y_max+1) accepts.

Test Plan:
1. x_max=2, y_max=1, start, 6 raster-order pixels with colours 1..6, mem_ready=1 -> writes addr 0..5 carrying data 1..6; frame_done pulses once, one cycle after DRAIN empties; seq_error=0; busy returns to 0.
2. Backpressure: mem_ready=0, in_valid held high -> exactly 4 accepts, then in_ready=0; mem_addr stays 0. Raise mem_ready -> addrs 0,1,2,3 in order, one per cycle, and in_ready reasserts.
3. Out-of-order: x_max=1, y_max=0, send (1,0) then (0,0) -> seq_error=1 after the first accept; writes to addr 1 then 0; frame_done still pulses. seq_error clears on the next start.
4. Reset mid-frame: after 3 accepts with mem_ready=0, assert reset asynchronously -> same cycle in_ready=0, mem_we=0, busy=0. After release, a new start with 1 pixel writes only that pixel.
5. Single-pixel frame: x_max=0, y_max=0, one pixel (0,0) colour 5 -> one write addr 0 data 5, then frame_done. start during RUN is ignored, with no change to latched maxima.
6. Max geometry: WIDTH=8, ADDR_WIDTH=16, x_max=y_max=255 -> pixel (255,255) writes addr 65535; frame_done only after the 65536th accept.
